pipelined_addsub: RTL and testbench

//   Chunk-pipelined unsigned adder/subtractor with per-sample mode select and valid tracking.

---
 rtl/pipelined_math_pkg.sv | 17 +
 rtl/addsub_stage.sv | 44 ++++
 rtl/pipelined_addsub.sv | 140 ++++++++++++++
 tb/tb_pipelined_addsub.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_math_pkg.sv
// Shared sizing helpers for the chunk-pipelined arithmetic units.
package pipelined_math_pkg;

    function automatic int ceil_division(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int stages_f(input int width, input int chunk);
        return ceil_division(width, chunk);
    endfunction

    // Every chunk is CHUNK bits except the top one, which takes the remainder.
    function automatic int chunk_width_f(input int width, input int chunk, input int k);
        return (k == stages_f(width, chunk) - 1) ? width - k * chunk : chunk;
    endfunction

endpackage

// File: rtl/addsub_stage.sv
// One pipeline stage: adds a CW-bit chunk plus incoming carry, registers sum and carry-out.
module addsub_stage
    import pipelined_math_pkg::*;
#(
    parameter int CW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout
);

    logic [CW:0]   total_w;
    logic [CW-1:0] sum_d, sum_q;
    logic          cout_d, cout_q;

    always_comb begin
        total_w = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (en) begin
            sum_d  = total_w[CW-1:0];
            cout_d = total_w[CW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: rtl/pipelined_addsub.sv
// Chunk-pipelined unsigned add/sub with skewed operands and deskewed result.
// Optional ADDSUB_SATURATE_EN clamps the result instead of wrapping.
module pipelined_addsub
    import pipelined_math_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic             sub,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    output logic [WIDTH:0]   out
);

    localparam int STAGES = stages_f(WIDTH, CHUNK);

    // Subtraction folds into addition: invert B up front, carry-in of chunk 0 is sub.
    logic [WIDTH-1:0] b_eff_w;
    logic [STAGES:0]  carry_w;
    logic [WIDTH-1:0] res_w;

    assign b_eff_w    = in2 ^ {WIDTH{sub}};
    assign carry_w[0] = sub;

    logic [STAGES-1:0] valid_d, valid_q, sub_d, sub_q;
    logic [STAGES:0]   valid_ext_w, sub_ext_w;

    assign valid_ext_w = {valid_q, in_valid};
    assign sub_ext_w   = {sub_q, sub};

    always_comb begin
        valid_d = valid_q;
        sub_d   = sub_q;
        if (en) begin
            valid_d = valid_ext_w[STAGES-1:0];
            sub_d   = sub_ext_w[STAGES-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            sub_q   <= '0;
        end else begin
            valid_q <= valid_d;
            sub_q   <= sub_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        localparam int CW = chunk_width_f(WIDTH, CHUNK, k);
        localparam int DS = STAGES - 1 - k;

        logic [2*CW-1:0] ab_w;
        logic [CW-1:0]   s_w;

        // Chunk k waits k cycles so it meets the carry produced by chunk k-1.
        if (k == 0) begin : g_noskew
            assign ab_w = {in1[LO +: CW], b_eff_w[LO +: CW]};
        end else begin : g_skew
            logic [2*CW-1:0] ab_d [k];
            logic [2*CW-1:0] ab_q [k];

            always_comb begin
                for (int i = 0; i < k; i++) ab_d[i] = ab_q[i];
                if (en) begin
                    ab_d[0] = {in1[LO +: CW], b_eff_w[LO +: CW]};
                    for (int i = 1; i < k; i++) ab_d[i] = ab_q[i-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < k; i++) ab_q[i] <= '0;
                end else begin
                    for (int i = 0; i < k; i++) ab_q[i] <= ab_d[i];
                end
            end

            assign ab_w = ab_q[k-1];
        end

        addsub_stage #(.CW(CW)) u_stage (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .a    (ab_w[2*CW-1:CW]),
            .b    (ab_w[CW-1:0]),
            .cin  (carry_w[k]),
            .sum  (s_w),
            .cout (carry_w[k+1])
        );

        // Early chunks are held back until the top chunk catches up.
        if (DS == 0) begin : g_nodeskew
            assign res_w[LO +: CW] = s_w;
        end else begin : g_deskew
            logic [CW-1:0] r_d [DS];
            logic [CW-1:0] r_q [DS];

            always_comb begin
                for (int i = 0; i < DS; i++) r_d[i] = r_q[i];
                if (en) begin
                    r_d[0] = s_w;
                    for (int i = 1; i < DS; i++) r_d[i] = r_q[i-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DS; i++) r_q[i] <= '0;
                end else begin
                    for (int i = 0; i < DS; i++) r_q[i] <= r_d[i];
                end
            end

            assign res_w[LO +: CW] = r_q[DS-1];
        end
    end

    // Carry xor mode is the add-overflow / sub-borrow flag in both builds.
    logic sub_last_w, flag_w;

    assign sub_last_w = sub_q[STAGES-1];
    assign flag_w     = carry_w[STAGES] ^ sub_last_w;
    assign out_valid  = valid_q[STAGES-1];

`ifdef ADDSUB_SATURATE_EN
    assign out = flag_w ? {1'b1, {WIDTH{~sub_last_w}}} : {1'b0, res_w};
`else
    assign out = {flag_w, res_w};
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed steps on (8,3), then random traffic on four geometries.
module tb_pipelined_addsub;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        in_valid = 1'b0;
    logic        sub = 1'b0;
    logic [12:0] in1 = '0;
    logic [12:0] in2 = '0;

    logic        v0, v1, v2, v3;
    logic [8:0]  o0, o1, o2;
    logic [13:0] o3;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(8), .CHUNK(3)) u_dut_8_3 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub),
        .in1(in1[7:0]), .in2(in2[7:0]), .out_valid(v0), .out(o0));
    pipelined_addsub #(.WIDTH(8), .CHUNK(8)) u_dut_8_8 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub),
        .in1(in1[7:0]), .in2(in2[7:0]), .out_valid(v1), .out(o1));
    pipelined_addsub #(.WIDTH(8), .CHUNK(1)) u_dut_8_1 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub),
        .in1(in1[7:0]), .in2(in2[7:0]), .out_valid(v2), .out(o2));
    pipelined_addsub #(.WIDTH(13), .CHUNK(4)) u_dut_13_4 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub),
        .in1(in1), .in2(in2), .out_valid(v3), .out(o3));

    logic [13:0] dout [4];
    logic        dval [4];
    assign dout[0] = {5'd0, o0};
    assign dout[1] = {5'd0, o1};
    assign dout[2] = {5'd0, o2};
    assign dout[3] = o3;
    assign dval[0] = v0;
    assign dval[1] = v1;
    assign dval[2] = v2;
    assign dval[3] = v3;

    int          wid [4] = '{8, 8, 8, 13};
    int          stg [4] = '{3, 1, 8, 4};
    int unsigned q [4][$];
    logic        exp_v [4];
    logic [13:0] exp_o [4];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [13:0] ref_out(input int w, input logic s,
                                            input logic [12:0] a, input logic [12:0] b);
        longint one = 1;
        longint m   = (one << w) - 1;
        longint x   = longint'(a) & m;
        longint y   = longint'(b) & m;
        longint r;
        r = s ? x - y : x + y;
`ifdef ADDSUB_SATURATE_EN
        if (!s && r > m) r = (one << w) | m;
        else if (s && r < 0) r = one << w;
`endif
        r = r & ((one << (w + 1)) - 1);
        return r[13:0];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            q[d].delete();
            for (int i = 0; i < stg[d] - 1; i++) q[d].push_back(32'd0);
            exp_v[d] = 1'b0;
            exp_o[d] = '0;
        end
    endtask

    // Each advancing edge enqueues the new sample and retires the one STAGES edges old.
    task automatic model_edge();
        int unsigned e;
        if (!rst && en) begin
            for (int d = 0; d < 4; d++) begin
                e = (in_valid ? 32'h8000_0000 : 32'd0) | {18'd0, ref_out(wid[d], sub, in1, in2)};
                q[d].push_back(e);
                e = q[d].pop_front();
                exp_v[d] = e[31];
                exp_o[d] = e[13:0];
            end
        end
    endtask

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    task automatic check_all(input string tag);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("%s valid dut%0d", tag, d), {13'd0, dval[d]}, {13'd0, exp_v[d]});
            if (exp_v[d]) check($sformatf("%s out dut%0d", tag, d), dout[d], exp_o[d]);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("%s out dut%0d", tag, d), dout[d], 14'd0);
            check($sformatf("%s valid dut%0d", tag, d), {13'd0, dval[d]}, 14'd0);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        model_edge();
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic s, input logic [12:0] a, input logic [12:0] b);
        in_valid = v;
        sub      = s;
        in1      = a;
        in2      = b;
    endtask

    function automatic logic [12:0] pick_operand();
        case ($urandom_range(0, 3))
            0:       return 13'h1FFF;
            1:       return 13'h0000;
            default: return 13'($urandom);
        endcase
    endfunction

    initial begin
        en = 1'b1;
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_zero("reset_immediate");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_zero("reset_hold");
        end
        rst = 1'b0;

        // add 200+100
        drive(1'b1, 1'b0, 13'd200, 13'd100);
        tick("add");
        drive(1'b0, 1'b0, 13'd0, 13'd0);
        tick("add");
        tick("add");
        check("add_200_100 out", dout[0], 14'h12C);
        check("add_200_100 valid", {13'd0, dval[0]}, 14'd1);
        tick("add_idle");
        check("add_idle valid", {13'd0, dval[0]}, 14'd0);

        // sub 5-10
        drive(1'b1, 1'b1, 13'd5, 13'd10);
        tick("sub");
        drive(1'b0, 1'b0, 13'd0, 13'd0);
        tick("sub");
        tick("sub");
`ifdef ADDSUB_SATURATE_EN
        check("sub_5_10 out", dout[0], 14'h100);
`else
        check("sub_5_10 out", dout[0], 14'h1FB);
`endif

        // 255+255 then 255-255 back to back
        drive(1'b1, 1'b0, 13'd255, 13'd255);
        tick("max");
        drive(1'b1, 1'b1, 13'd255, 13'd255);
        tick("max");
        drive(1'b0, 1'b0, 13'd0, 13'd0);
        tick("max");
`ifdef ADDSUB_SATURATE_EN
        check("add_255_255 out", dout[0], 14'h1FF);
`else
        check("add_255_255 out", dout[0], 14'h1FE);
`endif
        tick("max");
        check("sub_255_255 out", dout[0], 14'h000);
        check("sub_255_255 valid", {13'd0, dval[0]}, 14'd1);

        // stream with a two-cycle stall in the middle
        drive(1'b1, 1'b0, 13'd17, 13'd99);
        tick("stream");
        drive(1'b1, 1'b1, 13'd40, 13'd41);
        tick("stream");
        en = 1'b0;
        drive(1'b1, 1'b0, 13'd1, 13'd1);
        tick("stall");
        tick("stall");
        en = 1'b1;
        drive(1'b1, 1'b0, 13'd128, 13'd127);
        tick("stream");
        drive(1'b1, 1'b1, 13'd200, 13'd3);
        tick("stream");
        drive(1'b0, 1'b0, 13'd0, 13'd0);
        for (int i = 0; i < 9; i++) tick("drain");

        // reset while samples are in flight
        drive(1'b1, 1'b0, 13'd77, 13'd88);
        tick("pre_rst");
        drive(1'b1, 1'b1, 13'd9, 13'd2);
        tick("pre_rst");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_zero("mid_reset");
        @(posedge clk);
        #1;
        check_zero("mid_reset_hold");
        rst = 1'b0;
        drive(1'b0, 1'b0, 13'd0, 13'd0);
        for (int i = 0; i < 10; i++) tick("post_rst");

        for (int n = 0; n < 2000; n++) begin
            en = ($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_operand(), pick_operand());
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
